// File: rtl/map_mem_arbiter.sv
// map_mem_arbiter: shares one single-port map RAM between NUM_REQ lock-based
// readers (round-robin, hold timeout) and one write client that wins every
// arbitration point. Read data comes back one cycle after the address.
module map_mem_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int MAX_HOLD      = 16,
  localparam int ADDR_WIDTH   = $clog2(NUM_ROW * NUM_COL)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            read_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            read_granted,
  output logic [MAP_MEM_WIDTH-1:0]      map_mem_out,
  input  logic                          wr_req,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [MAP_MEM_WIDTH-1:0]      wr_data,
  output logic                          wr_ack,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_we,
  output logic [MAP_MEM_WIDTH-1:0]      ram_wdata,
  input  logic [MAP_MEM_WIDTH-1:0]      ram_rdata
);

  localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                    state_r;
  logic [REQ_W-1:0]          rr_ptr_r;
  logic [REQ_W-1:0]          owner_r;
  logic [HOLD_W-1:0]         hold_cnt_r;
  logic [ADDR_WIDTH-1:0]     wr_addr_r;
  logic [MAP_MEM_WIDTH-1:0]  map_last_r;

  logic [ADDR_WIDTH-1:0]     req_addr_s [NUM_REQ];
  logic                      pick_valid_s;
  logic [REQ_W-1:0]          pick_s;
  logic [NUM_REQ-1:0]        pick_onehot_s;
  logic [REQ_W-1:0]          next_ptr_s;
  logic                      grant_exit_s;

  // Split the flattened requester address bus into one address per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr_s[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins last.
  always_comb begin
    int idx_v;
    idx_v         = 0;
    pick_valid_s  = 1'b0;
    pick_s        = {REQ_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_v        = (int'(rr_ptr_r) + k) % NUM_REQ;
      pick_valid_s = pick_valid_s | read_req[REQ_W'(idx_v)];
      pick_s       = read_req[REQ_W'(idx_v)] ? REQ_W'(idx_v) : pick_s;
    end
    pick_onehot_s         = {NUM_REQ{1'b0}};
    pick_onehot_s[pick_s] = 1'b1;
  end

  // Grant release condition and the round-robin pointer that follows the owner.
  always_comb begin
    grant_exit_s = (!read_req[owner_r]) || (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
    if (owner_r == REQ_W'(NUM_REQ - 1)) begin
      next_ptr_s = {REQ_W{1'b0}};
    end else begin
      next_ptr_s = owner_r + REQ_W'(1);
    end
  end

  // RAM address: owner's address passes straight through while granted.
  always_comb begin
    case (state_r)
      ST_GRANT: ram_addr = req_addr_s[owner_r];
      ST_WRITE: ram_addr = wr_addr_r;
      default:  ram_addr = {ADDR_WIDTH{1'b0}};
    endcase
  end

  // Read data is live during a grant and frozen at its last value otherwise.
  always_comb begin
    if (state_r == ST_GRANT) begin
      map_mem_out = ram_rdata;
    end else begin
      map_mem_out = map_last_r;
    end
  end

  // Arbitration FSM with registered grant, write strobe and acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= {REQ_W{1'b0}};
      owner_r      <= {REQ_W{1'b0}};
      hold_cnt_r   <= {HOLD_W{1'b0}};
      wr_addr_r    <= {ADDR_WIDTH{1'b0}};
      map_last_r   <= {MAP_MEM_WIDTH{1'b0}};
      read_granted <= {NUM_REQ{1'b0}};
      wr_ack       <= 1'b0;
      ram_we       <= 1'b0;
      ram_wdata    <= {MAP_MEM_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_req) begin
            state_r   <= ST_WRITE;
            wr_addr_r <= wr_addr;
            ram_wdata <= wr_data;
            ram_we    <= 1'b1;
            wr_ack    <= 1'b1;
          end else if (pick_valid_s) begin
            state_r      <= ST_GRANT;
            owner_r      <= pick_s;
            hold_cnt_r   <= {HOLD_W{1'b0}};
            read_granted <= pick_onehot_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          map_last_r <= ram_rdata;
          if (grant_exit_s) begin
            state_r      <= ST_IDLE;
            read_granted <= {NUM_REQ{1'b0}};
            rr_ptr_r     <= next_ptr_s;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_WRITE: begin
          state_r <= ST_IDLE;
          ram_we  <= 1'b0;
          wr_ack  <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          read_granted <= {NUM_REQ{1'b0}};
          ram_we       <= 1'b0;
          wr_ack       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_mem_arbiter.sv
// tb_map_mem_arbiter: directed vector table plus hand-written sequences for
// round-robin timeout, write-during-grant and asynchronous reset mid-grant.
module tb_map_mem_arbiter;

  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic [1:0]    read_req;
  logic [2*AW-1:0] req_addr;
  logic [1:0]    read_granted;
  logic [1:0]    map_mem_out;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic          wr_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [1:0]    ram_wdata;
  logic [1:0]    ram_rdata;

  logic [1:0]    mem [0:255];
  logic          preload;

  int n_vec;
  int n_err;

  map_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .read_req     (read_req),
    .req_addr     (req_addr),
    .read_granted (read_granted),
    .map_mem_out  (map_mem_out),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] ram_init(input int a);
    if (a == 20) return 2'd2;
    else if (a == 40) return 2'd3;
    else return 2'(a % 3);
  endfunction

  // Map RAM model: one-cycle synchronous read, write on ram_we.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= ram_init(i);
      ram_rdata <= 2'd0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [1:0]    rr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          wr;
    logic [AW-1:0] wa;
    logic [1:0]    wd;
    logic [1:0]    eg;
    logic          ewe;
    logic          eack;
    logic          ca;
    logic [AW-1:0] ea;
    logic          cd;
    logic [1:0]    ed;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  initial begin
    int ack_k;
    int ack_cnt;
    logic [1:0] exp_g;
    n_vec = 0;
    n_err = 0;

    //            rr     a0     a1     wr    wa     wd    eg     we    ack   ca    ea     cd    ed
    tbl[0]  = '{2'b01, 8'd20, 8'd0,  1'b0, 8'd0,  2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 2'd0};
    tbl[1]  = '{2'b01, 8'd20, 8'd0,  1'b0, 8'd0,  2'd0, 2'b01, 1'b0, 1'b0, 1'b1, 8'd20, 1'b0, 2'd0};
    tbl[2]  = '{2'b01, 8'd21, 8'd0,  1'b0, 8'd0,  2'd0, 2'b01, 1'b0, 1'b0, 1'b1, 8'd21, 1'b1, 2'd2};
    tbl[3]  = '{2'b01, 8'd39, 8'd0,  1'b0, 8'd0,  2'd0, 2'b01, 1'b0, 1'b0, 1'b1, 8'd39, 1'b1, 2'd0};
    tbl[4]  = '{2'b01, 8'd1,  8'd0,  1'b0, 8'd0,  2'd0, 2'b01, 1'b0, 1'b0, 1'b1, 8'd1,  1'b1, 2'd0};
    tbl[5]  = '{2'b00, 8'd1,  8'd0,  1'b0, 8'd0,  2'd0, 2'b01, 1'b0, 1'b0, 1'b1, 8'd1,  1'b1, 2'd1};
    tbl[6]  = '{2'b00, 8'd1,  8'd0,  1'b0, 8'd0,  2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 2'd1};
    tbl[7]  = '{2'b10, 8'd0,  8'd40, 1'b1, 8'd40, 2'd1, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 2'd1};
    tbl[8]  = '{2'b10, 8'd0,  8'd40, 1'b1, 8'd40, 2'd1, 2'b00, 1'b1, 1'b1, 1'b1, 8'd40, 1'b1, 2'd1};
    tbl[9]  = '{2'b10, 8'd0,  8'd40, 1'b0, 8'd0,  2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 2'd1};
    tbl[10] = '{2'b10, 8'd0,  8'd40, 1'b0, 8'd0,  2'd0, 2'b10, 1'b0, 1'b0, 1'b1, 8'd40, 1'b0, 2'd0};
    tbl[11] = '{2'b10, 8'd0,  8'd40, 1'b0, 8'd0,  2'd0, 2'b10, 1'b0, 1'b0, 1'b1, 8'd40, 1'b1, 2'd1};
    tbl[12] = '{2'b00, 8'd0,  8'd40, 1'b0, 8'd0,  2'd0, 2'b10, 1'b0, 1'b0, 1'b1, 8'd40, 1'b1, 2'd1};
    tbl[13] = '{2'b00, 8'd0,  8'd0,  1'b0, 8'd0,  2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 2'd1};
    tbl[14] = '{2'b01, 8'd0,  8'd0,  1'b1, 8'd50, 2'd3, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 2'd1};
    tbl[15] = '{2'b00, 8'd0,  8'd0,  1'b1, 8'd50, 2'd3, 2'b00, 1'b1, 1'b1, 1'b1, 8'd50, 1'b1, 2'd1};
    tbl[16] = '{2'b00, 8'd0,  8'd0,  1'b0, 8'd0,  2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 2'd0};
    tbl[17] = '{2'b00, 8'd0,  8'd0,  1'b0, 8'd0,  2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 2'd0};

    // Reset held with both readers requesting.
    preload  = 1'b1;
    rst      = 1'b0;
    read_req = 2'b11;
    req_addr = '0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      check("rst_granted", 32'(read_granted), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_ack", 32'(wr_ack), 32'd0);
    end
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_map_out", 32'(map_mem_out), 32'd0);
    tick();
    preload = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("rel_granted_c0", 32'(read_granted), 32'd0);
    tick();
    @(negedge clk);
    check("rel_granted_c1", 32'(read_granted), 32'b01);
    tick();
    read_req = 2'b00;
    @(negedge clk);
    check("rel_granted_c2", 32'(read_granted), 32'b01);
    tick();
    @(negedge clk);
    check("rel_granted_c3", 32'(read_granted), 32'b00);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);

    // Table-driven vectors: single reader, write priority, dropped request.
    for (int i = 0; i < NVEC; i++) begin
      tick();
      read_req = tbl[i].rr;
      req_addr = {tbl[i].a1, tbl[i].a0};
      wr_req   = tbl[i].wr;
      wr_addr  = tbl[i].wa;
      wr_data  = tbl[i].wd;
      @(negedge clk);
      check($sformatf("v%0d_granted", i), 32'(read_granted), 32'(tbl[i].eg));
      check($sformatf("v%0d_we", i), 32'(ram_we), 32'(tbl[i].ewe));
      check($sformatf("v%0d_ack", i), 32'(wr_ack), 32'(tbl[i].eack));
      if (tbl[i].ca) check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].ea));
      if (tbl[i].cd) check($sformatf("v%0d_map_out", i), 32'(map_mem_out), 32'(tbl[i].ed));
      if (tbl[i].ewe) check($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(tbl[i].wd));
    end

    // Round-robin with both readers held: each grant ends at the hold timeout.
    for (int k = 0; k <= 68; k++) begin
      tick();
      read_req = (k < 68) ? 2'b11 : 2'b00;
      req_addr = {8'd3, 8'd2};
      @(negedge clk);
      if (k == 0) begin
        exp_g = 2'b00;
      end else if (((k - 1) % 17) < 16) begin
        exp_g = ((((k - 1) / 17) % 2) == 0) ? 2'b01 : 2'b10;
      end else begin
        exp_g = 2'b00;
      end
      check($sformatf("rr_k%0d_granted", k), 32'(read_granted), 32'(exp_g));
      check($sformatf("rr_k%0d_we", k), 32'(ram_we), 32'd0);
    end

    // Write raised during a grant waits for the grant to end.
    tick();
    read_req = 2'b01;
    req_addr = {8'd0, 8'd9};
    @(negedge clk);
    check("wg_w0_granted", 32'(read_granted), 32'b00);
    tick();
    wr_req  = 1'b1;
    wr_addr = 8'd60;
    wr_data = 2'd2;
    @(negedge clk);
    check("wg_w1_granted", 32'(read_granted), 32'b01);
    ack_k   = -1;
    ack_cnt = 0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      read_req = (k < 5) ? 2'b01 : 2'b00;
      wr_req   = (ack_k >= 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      check($sformatf("wg_k%0d_overlap", k), 32'((read_granted != 2'b00) && ram_we), 32'd0);
      if (wr_ack) begin
        ack_cnt++;
        if (ack_k < 0) ack_k = k;
        check("wg_ack_we", 32'(ram_we), 32'd1);
        check("wg_ack_addr", 32'(ram_addr), 32'd60);
        check("wg_ack_wdata", 32'(ram_wdata), 32'd2);
      end
    end
    check("wg_ack_cycle", 32'(ack_k), 32'd7);
    check("wg_ack_count", 32'(ack_cnt), 32'd1);
    check("wg_mem60", 32'(mem[60]), 32'd2);

    // Asynchronous reset in the middle of a grant with a write pending.
    tick();
    read_req = 2'b10;
    req_addr = {8'd5, 8'd0};
    @(negedge clk);
    check("ar_idle_granted", 32'(read_granted), 32'b00);
    tick();
    @(negedge clk);
    check("ar_grant1", 32'(read_granted), 32'b10);
    tick();
    wr_req  = 1'b1;
    wr_addr = 8'd70;
    wr_data = 2'd2;
    @(negedge clk);
    check("ar_grant1_hold", 32'(read_granted), 32'b10);
    check("ar_no_ack_pre", 32'(wr_ack), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("ar_async_granted", 32'(read_granted), 32'b00);
    check("ar_async_addr", 32'(ram_addr), 32'd0);
    check("ar_async_map_out", 32'(map_mem_out), 32'd0);
    check("ar_async_we", 32'(ram_we), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      check("ar_held_ack", 32'(wr_ack), 32'd0);
      check("ar_held_we", 32'(ram_we), 32'd0);
      check("ar_held_granted", 32'(read_granted), 32'b00);
    end
    tick();
    rst      = 1'b1;
    wr_req   = 1'b0;
    read_req = 2'b11;
    @(negedge clk);
    check("ar_rel_granted", 32'(read_granted), 32'b00);
    tick();
    @(negedge clk);
    check("ar_rr_ptr0_grant", 32'(read_granted), 32'b01);
    check("ar_mem70_untouched", 32'(mem[70]), 32'd1);
    tick();
    read_req = 2'b00;
    @(negedge clk);
    check("ar_tail_granted", 32'(read_granted), 32'b01);
    tick();
    @(negedge clk);
    check("ar_final_idle", 32'(read_granted), 32'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/map_mem_arbiter.md
Name: map_mem_arbiter

Overview:
- Responder side of the map-memory read handshake (read_req / read_granted / map_addr / map_mem_in) used by each player's obstacle checker.
- Arbitrates one single-port map RAM (NUM_ROW x NUM_COL tiles) among NUM_REQ read requesters plus one write client (bomb placement, block destruction).
- Reads are lock-based with round-robin fairness and a hold timeout. Writes take priority at every arbitration point.

Parameters:
- NUM_REQ, 2, number of read requesters (players)
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- MAP_MEM_WIDTH, 2, bits per tile
- MAX_HOLD, 16, maximum cycles a read grant may be held
- ADDR_WIDTH, $clog2(NUM_ROW*NUM_COL), localparam, tile address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- read_req  in  NUM_REQ  per-requester read lock request, level
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened per-requester tile address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_granted  out  NUM_REQ  one-hot grant, registered
- map_mem_out  out  MAP_MEM_WIDTH  read data broadcast to all requesters
- wr_req  in  1  write request, level, held until wr_ack
- wr_addr  in  ADDR_WIDTH  write tile address
- wr_data  in  MAP_MEM_WIDTH  write tile value
- wr_ack  out  1  one-cycle pulse when the write is committed
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  MAP_MEM_WIDTH  RAM write data
- ram_rdata  in  MAP_MEM_WIDTH  RAM read data, 1-cycle synchronous latency

Behaviour:
- Reset (rst low, async) forces:
  - state=IDLE, rr_ptr=0, owner=0, hold_cnt=0
  - read_granted=0, wr_ack=0, ram_we=0, ram_addr=0, ram_wdata=0, map_mem_out=0
- Reset mid-grant or mid-write drops everything immediately. The pending write is not committed and no wr_ack is issued.
- FSM has three states: IDLE, GRANT, WRITE.
- IDLE:
  - If wr_req=1: go to WRITE. Writes beat reads.
  - Else if any read_req: pick the first asserted requester scanning from rr_ptr upward, mod NUM_REQ. Set owner, hold_cnt=0, go to GRANT.
  - read_granted[owner] rises on the cycle after the request is sampled.
- GRANT:
  - read_granted[owner]=1; all other grant bits are 0.
  - ram_addr = req_addr[owner], combinational passthrough.
  - map_mem_out = ram_rdata. Data for the address presented in cycle T is valid in cycle T+1.
  - hold_cnt increments each cycle.
  - Exit to IDLE when read_req[owner]=0 or hold_cnt==MAX_HOLD-1.
  - On exit: read_granted drops the next cycle and rr_ptr = (owner+1) mod NUM_REQ.
  - A forced timeout exit still advances rr_ptr. The timed-out requester re-competes normally.
- WRITE (exactly 1 cycle):
  - ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1.
  - Next state IDLE. rr_ptr is unchanged.
- Turnaround: at least one IDLE cycle between consecutive grants and between a grant and a write. read_granted is never asserted to two requesters, and never asserted in the same cycle as ram_we.
- A write requested during GRANT waits until that grant ends, then wins the next IDLE. Worst-case write latency is MAX_HOLD+2 cycles.
- Simultaneous wr_req and read_req in IDLE: the write goes first, and the reads are granted afterwards in round-robin order.
- A read_req deasserted before it is granted is dropped with no grant.
- In IDLE and WRITE, map_mem_out holds its last value. Requesters must ignore it outside their grant.
- ram_addr wraps nothing: out-of-range addresses (>= NUM_ROW*NUM_COL) pass through unchanged. Range checking is the requester's duty.

Test Plan:
- Reset: hold rst low 3 cycles with read_req=2'b11 -> read_granted=0, ram_we=0, wr_ack=0 throughout; first grant goes to requester 0 two cycles after rst rises.
- Single reader: read_req[0]=1 for 5 cycles with req_addr0 = 20, 21, 39, 1; RAM preloaded so tile 20=2 -> read_granted[0] high from cycle 1; map_mem_out=2 the cycle after address 20; grant drops one cycle after read_req falls.
- Round-robin: read_req=2'b11 held continuously, each requester's grant ends at timeout -> grant sequence 0,1,0,1; each grant lasts exactly MAX_HOLD=16 cycles; one idle cycle between grants.
- Write priority: in IDLE, assert wr_req (wr_addr=40, wr_data=1) together with read_req[1] -> ram_we and wr_ack pulse 1 cycle before any grant; a subsequent read of tile 40 returns 1.
- Write during grant: wr_req rises while requester 0 is granted, and read_req[0] drops 4 cycles later -> ram_we never overlaps read_granted; wr_ack occurs 2 cycles after read_req[0] falls.
- Async reset mid-grant: pull rst low asynchronously mid-cycle during GRANT with wr_req pending -> read_granted falls without waiting for clk; no wr_ack; state returns to IDLE with rr_ptr=0.
